// File: rtl/render_sequencer_pkg.sv
// Shared types and helpers for the frame render sequencer.
package render_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KICK,
        ST_LOAD_WAIT,
        ST_SETUP,
        ST_TRI_KICK,
        ST_DRAW,
        ST_NEXT,
        ST_DISPLAY
    } seq_state_t;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int TMR_W     = 16;
    localparam int PIX_CNT_W = 20;

    // Video buffer address layout: x in the upper bits, y in the lower nine.
    function automatic logic [18:0] buff_addr_cat(input logic [9:0] x, input logic [8:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/render_sequencer_buff_port_mux.sv
// Single-port video buffer arbitration: rasterizer writes while drawing,
// VGA scan reads otherwise. Off-screen rasterizer pixels are dropped here.
module buff_port_mux
    import render_sequencer_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic        draw_active,
    input  logic [9:0]  tri_x,
    input  logic [8:0]  tri_y,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    output logic        we,
    output logic [18:0] addr,
    output logic        wr_data
);

    logic in_bounds;

    // Clip compare, then pick the write or scan address.
    always_comb begin
        in_bounds = ({1'b0, tri_x} < 11'(H_RES)) && ({1'b0, tri_y} < 10'(V_RES));
        we        = draw_active && in_bounds;
        addr      = we ? buff_addr_cat(tri_x, tri_y) : buff_addr_cat(pix_x, pix_y);
        wr_data   = we;
    end

endmodule

// File: rtl/render_sequencer.sv
// Frame-level controller: runs the ROM-to-RAM loader, feeds each stored
// triangle to the rasterizer, then hands the video buffer to the display.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | waiting for start after reset
// LOAD_KICK  | one-cycle reset/start pulse to the loader
// LOAD_WAIT  | waiting for loader_finish (bounded by LOAD_TIMEOUT)
// SETUP      | present triangle index to RAM, wait RAM_LAT cycles
// TRI_KICK   | one-cycle restart pulse to the rasterizer
// DRAW       | forward rasterizer pixels until tri_finish / timeout
// NEXT       | advance to the next triangle or finish the frame
// DISPLAY    | frame complete, VGA owns the buffer
module render_sequencer
    import render_sequencer_pkg::*;
#(
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int RAM_LAT      = 1,
    parameter int LOAD_TIMEOUT = 1024,
    parameter int DRAW_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  tri_count,
    output logic        loader_reset,
    output logic        loader_start,
    input  logic        loader_finish,
    output logic [7:0]  ram_read_addr,
    output logic        tri_reset,
    input  logic        tri_finish,
    input  logic [9:0]  tri_x,
    input  logic [8:0]  tri_y,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic        buff_we,
    output logic [18:0] buff_addr,
    output logic        buff_wr_data,
    output logic        display_en,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [19:0] pix_written
);

    // Timer reload values: each timed state lasts exactly its parameter in cycles.
    localparam logic [TMR_W-1:0] LOAD_TMR = TMR_W'(LOAD_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RAM_TMR  = TMR_W'(RAM_LAT - 1);
    localparam logic [TMR_W-1:0] DRAW_TMR = TMR_W'(DRAW_TIMEOUT - 1);

    seq_state_t           state, state_nxt;
    logic [TMR_W-1:0]     tmr;
    logic [7:0]           idx;
    logic                 err_r;
    logic                 done_r;
    logic [PIX_CNT_W-1:0] pix_cnt;
    logic                 tmr_zero;
    logic                 draw_active;
    logic                 load_to;
    logic                 draw_to;
    logic                 pix_y_unused;

    assign tmr_zero     = (tmr == '0);
    assign draw_active  = (state == ST_DRAW) && !tri_finish;
    assign load_to      = (state == ST_LOAD_WAIT) && !loader_finish && tmr_zero;
    assign draw_to      = (state == ST_DRAW) && !tri_finish && tmr_zero;
    assign pix_y_unused = pix_y[9];

    assign ram_read_addr = idx;
    assign error         = err_r;
    assign done          = done_r;
    assign pix_written   = pix_cnt;

    buff_port_mux #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_buff_port_mux (
        .draw_active (draw_active),
        .tri_x       (tri_x),
        .tri_y       (tri_y),
        .pix_x       (pix_x),
        .pix_y       (pix_y[8:0]),
        .we          (buff_we),
        .addr        (buff_addr),
        .wr_data     (buff_wr_data)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode and per-state control outputs.
    always_comb begin
        state_nxt    = state;
        loader_reset = 1'b0;
        loader_start = 1'b0;
        tri_reset    = 1'b0;
        display_en   = 1'b0;
        busy         = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_LOAD_KICK;
            end
            ST_LOAD_KICK: begin
                loader_reset = 1'b1;
                loader_start = 1'b1;
                state_nxt    = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (loader_finish) state_nxt = (tri_count == 8'd0) ? ST_DISPLAY : ST_SETUP;
                else if (tmr_zero) state_nxt = ST_DISPLAY;
            end
            ST_SETUP: begin
                if (tmr_zero) state_nxt = ST_TRI_KICK;
            end
            ST_TRI_KICK: begin
                tri_reset = 1'b1;
                state_nxt = ST_DRAW;
            end
            ST_DRAW: begin
                if (tri_finish || tmr_zero) state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                // >= rather than == so a tri_count lowered mid-frame still ends the frame.
                if (({1'b0, idx} + 9'd1) >= {1'b0, tri_count}) state_nxt = ST_DISPLAY;
                else                                            state_nxt = ST_SETUP;
            end
            ST_DISPLAY: begin
                busy       = 1'b0;
                display_en = 1'b1;
                if (start) state_nxt = ST_LOAD_KICK;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Down-counter reloaded on entry to each timed state, holds at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr <= '0;
        end else if (state_nxt != state) begin
            case (state_nxt)
                ST_LOAD_WAIT: tmr <= LOAD_TMR;
                ST_SETUP:     tmr <= RAM_TMR;
                ST_DRAW:      tmr <= DRAW_TMR;
                default:      tmr <= '0;
            endcase
        end else if (!tmr_zero) begin
            tmr <= tmr - 1'b1;
        end
    end

    // Frame bookkeeping: triangle index, sticky error, pixel count, done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx     <= '0;
            err_r   <= 1'b0;
            pix_cnt <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= (state_nxt == ST_DISPLAY) && (state != ST_DISPLAY);
            if (state_nxt == ST_LOAD_KICK) begin
                idx     <= '0;
                err_r   <= 1'b0;
                pix_cnt <= '0;
            end else begin
                if (load_to || draw_to) err_r <= 1'b1;
                if (buff_we && (pix_cnt != '1)) pix_cnt <= pix_cnt + 1'b1;
                if ((state == ST_NEXT) && (state_nxt == ST_SETUP)) idx <= idx + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_render_sequencer.sv
// Self-checking bench for render_sequencer: a default instance plus one with a
// short draw timeout, both driven from the same loader/rasterizer stimulus.
module tb_render_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, start, loader_finish, tri_finish;
    logic [7:0]  tri_count;
    logic [9:0]  tri_x, pix_x, pix_y;
    logic [8:0]  tri_y;

    logic        loader_reset, loader_start, tri_reset, buff_we, buff_wr_data;
    logic        display_en, busy, done, error;
    logic [7:0]  ram_read_addr;
    logic [18:0] buff_addr;
    logic [19:0] pix_written;

    logic        t_loader_reset, t_loader_start, t_tri_reset, t_buff_we, t_buff_wr_data;
    logic        t_display_en, t_busy, t_done, t_error;
    logic [7:0]  t_ram_read_addr;
    logic [18:0] t_buff_addr;
    logic [19:0] t_pix_written;

    int tests = 0;
    int fails = 0;
    int n_tri_reset = 0, n_loader_start = 0, n_done = 0;
    logic [7:0] exp_addr_q[$];

    always #5 clk = ~clk;

    render_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .tri_count(tri_count),
        .loader_reset(loader_reset), .loader_start(loader_start), .loader_finish(loader_finish),
        .ram_read_addr(ram_read_addr), .tri_reset(tri_reset), .tri_finish(tri_finish),
        .tri_x(tri_x), .tri_y(tri_y), .pix_x(pix_x), .pix_y(pix_y),
        .buff_we(buff_we), .buff_addr(buff_addr), .buff_wr_data(buff_wr_data),
        .display_en(display_en), .busy(busy), .done(done), .error(error),
        .pix_written(pix_written)
    );

    render_sequencer #(.DRAW_TIMEOUT(16)) dut_to (
        .clk(clk), .reset_n(reset_n), .start(start), .tri_count(tri_count),
        .loader_reset(t_loader_reset), .loader_start(t_loader_start), .loader_finish(loader_finish),
        .ram_read_addr(t_ram_read_addr), .tri_reset(t_tri_reset), .tri_finish(tri_finish),
        .tri_x(tri_x), .tri_y(tri_y), .pix_x(pix_x), .pix_y(pix_y),
        .buff_we(t_buff_we), .buff_addr(t_buff_addr), .buff_wr_data(t_buff_wr_data),
        .display_en(t_display_en), .busy(t_busy), .done(t_done), .error(t_error),
        .pix_written(t_pix_written)
    );

    always @(negedge clk) begin
        if (tri_reset)    n_tri_reset++;
        if (loader_start) n_loader_start++;
        if (done)         n_done++;
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return loader_start;
            1:       return tri_reset;
            2:       return done;
            3:       return t_tri_reset;
            4:       return t_done;
            5:       return t_error;
            default: return 1'b0;
        endcase
    endfunction

    // Waits (at negedges) for a DUT signal; n = negedges waited.
    task automatic wait_on(input int which, input int bound, output int n, output bit seen);
        n = 0;
        seen = sig(which);
        while (!seen && n < bound) begin
            @(negedge clk);
            n++;
            seen = sig(which);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; loader_finish = 1'b0; tri_finish = 1'b0;
        tri_count = 8'd0; tri_x = 10'd100; tri_y = 9'd50; pix_x = 10'd0; pix_y = 10'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Loader model: finish arrives 'delay' cycles after the kick cycle.
    task automatic frame_load(input int delay, output bit ok);
        int n;
        wait_on(0, 5, n, ok);
        if (ok) begin
            repeat (delay) @(negedge clk);
            loader_finish = 1'b1;
            @(negedge clk);
            loader_finish = 1'b0;
        end
    endtask

    // Rasterizer model: called in the tri_reset cycle, finish 'len' cycles later.
    task automatic draw_tri(input int len, input int start_at);
        for (int j = 1; j < len; j++) begin
            @(negedge clk);
            start = (j == start_at);
            tri_x = 10'(100 + j);
            tri_y = 9'd50;
        end
        @(negedge clk);
        start = 1'b0;
        tri_finish = 1'b1;
        @(negedge clk);
        tri_finish = 1'b0;
    endtask

    task automatic test_reset();
        int n, d0; bit seen, ok;
        reset_n = 1'b0; start = 1'b0; loader_finish = 1'b0; tri_finish = 1'b0;
        tri_count = 8'd2; tri_x = 10'd100; tri_y = 9'd50; pix_x = 10'd0; pix_y = 10'd0;
        @(negedge clk);
        tests++;
        if ({loader_reset, loader_start, ram_read_addr, tri_reset, buff_we, buff_addr, buff_wr_data,
             display_en, busy, done, error, pix_written} !== 56'd0) begin
            fails++; $display("FAIL reset_values: outputs not all zero");
        end
        reset_n = 1'b1;
        @(negedge clk);
        d0 = n_done;
        pulse_start();
        frame_load(4, ok);
        wait_on(1, 20, n, seen);
        draw_tri(10, 0);
        wait_on(1, 20, n, seen);
        tests++;
        if (!ok || !seen) begin fails++; $display("FAIL reset_reach_tri2: ok=%0d seen=%0d want 1 1", ok, seen); end
        @(negedge clk);
        #1;
        tests++;
        if (buff_we !== 1'b1 || ram_read_addr !== 8'd1) begin
            fails++; $display("FAIL reset_pre_draw: we=%0b addr=%0d want 1 1", buff_we, ram_read_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({loader_reset, loader_start, ram_read_addr, tri_reset, buff_we, buff_addr, buff_wr_data,
             display_en, busy, done, error, pix_written} !== 56'd0) begin
            fails++; $display("FAIL reset_async: outputs not zero, we=%0b pix=%0d", buff_we, pix_written);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, display_en, done} !== 3'b000 || n_done != d0) begin
            fails++; $display("FAIL reset_idle: busy/disp/done=%b done_pulses=%0d want 000 0",
                              {busy, display_en, done}, n_done - d0);
        end
    endtask

    task automatic test_frame();
        int n, r0, d0, exp_pix; bit seen, ok;
        logic [7:0] ea;
        do_reset();
        r0 = n_tri_reset; d0 = n_done; exp_pix = 0;
        tri_count = 8'd2;
        exp_addr_q.push_back(8'd0);
        exp_addr_q.push_back(8'd1);
        pulse_start();
        frame_load(9, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL frame_kick: loader_start=%0b want 1", loader_start); end
        for (int t = 0; t < 2; t++) begin
            wait_on(1, 20, n, seen);
            tests++;
            if (!seen || exp_addr_q.size() == 0) begin
                fails++; $display("FAIL frame_tri_reset: tri %0d not seen", t);
            end else begin
                ea = exp_addr_q.pop_front();
                if (ram_read_addr !== ea) begin
                    fails++; $display("FAIL frame_ram_addr: got %0d want %0d", ram_read_addr, ea);
                end
                draw_tri(50, 0);
                exp_pix += 49;
            end
        end
        wait_on(2, 10, n, seen);
        tests++;
        if (!seen || display_en !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || pix_written !== 20'(exp_pix)) begin
            fails++; $display("FAIL frame_end: done=%0b disp=%0b err=%0b busy=%0b pix=%0d want 1 1 0 0 %0d",
                              done, display_en, error, busy, pix_written, exp_pix);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || display_en !== 1'b1) begin
            fails++; $display("FAIL frame_done_width: done=%0b disp=%0b want 0 1", done, display_en);
        end
        tests++;
        if (n_tri_reset - r0 != 2 || n_done - d0 != 1 || exp_addr_q.size() != 0) begin
            fails++; $display("FAIL frame_pulses: tri_reset=%0d done=%0d left=%0d want 2 1 0",
                              n_tri_reset - r0, n_done - d0, exp_addr_q.size());
        end
    endtask

    task automatic test_clip();
        int n; bit seen, ok;
        logic [18:0] exp_rd;
        do_reset();
        tri_count = 8'd1; tri_x = 10'd700; tri_y = 9'd10;
        pix_x = 10'd5; pix_y = 10'd7;
        exp_rd = {pix_x, pix_y[8:0]};
        pulse_start();
        frame_load(3, ok);
        wait_on(1, 20, n, seen);
        tests++;
        if (!ok || !seen) begin fails++; $display("FAIL clip_reach_draw: ok=%0d seen=%0d want 1 1", ok, seen); end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            tri_x = 10'd700; tri_y = 9'd10;
            #1;
            tests++;
            if (buff_we !== 1'b0 || buff_addr !== exp_rd) begin
                fails++; $display("FAIL clip_x700: we=%0b addr=%h want 0 %h", buff_we, buff_addr, exp_rd);
            end
        end
        @(negedge clk);
        tests++;
        if (pix_written !== 20'd0) begin fails++; $display("FAIL clip_count: got %0d want 0", pix_written); end
        tri_x = 10'd639; tri_y = 9'd479;
        #1;
        tests++;
        if (buff_we !== 1'b1 || buff_wr_data !== 1'b1 || buff_addr !== {10'd639, 9'd479}) begin
            fails++; $display("FAIL clip_edge_write: we=%0b d=%0b addr=%h want 1 1 %h",
                              buff_we, buff_wr_data, buff_addr, {10'd639, 9'd479});
        end
        @(negedge clk);
        tri_x = 10'd640; tri_y = 9'd0;
        #1;
        tests++;
        if (pix_written !== 20'd1 || buff_we !== 1'b0) begin
            fails++; $display("FAIL clip_x640: pix=%0d we=%0b want 1 0", pix_written, buff_we);
        end
        @(negedge clk);
        tri_x = 10'd0; tri_y = 9'd480;
        #1;
        tests++;
        if (buff_we !== 1'b0) begin fails++; $display("FAIL clip_y480: we=%0b want 0", buff_we); end
        @(negedge clk);
        tri_x = 10'd5; tri_y = 9'd5; tri_finish = 1'b1;
        #1;
        tests++;
        if (buff_we !== 1'b0) begin fails++; $display("FAIL clip_finish_nowrite: we=%0b want 0", buff_we); end
        @(negedge clk);
        tri_finish = 1'b0;
        wait_on(2, 10, n, seen);
        pix_x = 10'd123; pix_y = 10'h3AB;
        #1;
        tests++;
        if (!seen || pix_written !== 20'd1 || buff_we !== 1'b0 || buff_addr !== {10'd123, 9'h1AB}) begin
            fails++; $display("FAIL clip_display_read: done=%0b pix=%0d we=%0b addr=%h want 1 1 0 %h",
                              seen, pix_written, buff_we, buff_addr, {10'd123, 9'h1AB});
        end
        @(negedge clk);
    endtask

    task automatic test_zero_tri();
        int r0, d0; bit ok;
        do_reset();
        r0 = n_tri_reset; d0 = n_done;
        tri_count = 8'd0;
        pulse_start();
        frame_load(3, ok);
        tests++;
        if (!ok || done !== 1'b1 || display_en !== 1'b1) begin
            fails++; $display("FAIL zero_direct: ok=%0d done=%0b disp=%0b want 1 1 1", ok, done, display_en);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (n_tri_reset != r0 || n_done - d0 != 1 || display_en !== 1'b1) begin
            fails++; $display("FAIL zero_pulses: tri_reset=%0d done=%0d disp=%0b want 0 1 1",
                              n_tri_reset - r0, n_done - d0, display_en);
        end
    endtask

    task automatic test_draw_timeout();
        int n; bit seen, ok;
        do_reset();
        tri_count = 8'd2;
        pulse_start();
        frame_load(2, ok);
        wait_on(3, 20, n, seen);
        tests++;
        if (!ok || !seen) begin fails++; $display("FAIL to_first_kick: ok=%0d seen=%0d want 1 1", ok, seen); end
        wait_on(5, 40, n, seen);
        tests++;
        if (!seen || n != 17 || t_busy !== 1'b1) begin
            fails++; $display("FAIL to_error_time: seen=%0d cycles=%0d busy=%0b want 1 17 1", seen, n, t_busy);
        end
        wait_on(3, 10, n, seen);
        tests++;
        if (!seen || n != 2 || t_ram_read_addr !== 8'd1) begin
            fails++; $display("FAIL to_second_kick: seen=%0d cycles=%0d addr=%0d want 1 2 1", seen, n, t_ram_read_addr);
        end
        wait_on(4, 40, n, seen);
        tests++;
        if (!seen || n != 18 || t_error !== 1'b1 || t_display_en !== 1'b1) begin
            fails++; $display("FAIL to_display: seen=%0d cycles=%0d err=%0b disp=%0b want 1 18 1 1",
                              seen, n, t_error, t_display_en);
        end
    endtask

    task automatic test_restart();
        int n, s0; bit seen, ok;
        do_reset();
        tri_count = 8'd1;
        s0 = n_loader_start;
        pulse_start();
        frame_load(3, ok);
        wait_on(1, 20, n, seen);
        draw_tri(11, 4);
        wait_on(2, 10, n, seen);
        tests++;
        if (!ok || !seen || pix_written !== 20'd10 || n_loader_start - s0 != 1) begin
            fails++; $display("FAIL restart_ignored: done=%0d pix=%0d kicks=%0d want 1 10 1",
                              seen, pix_written, n_loader_start - s0);
        end
        pulse_start();
        tests++;
        if (display_en !== 1'b0 || loader_start !== 1'b1 || pix_written !== 20'd0 || busy !== 1'b1) begin
            fails++; $display("FAIL restart_accept: disp=%0b kick=%0b pix=%0d busy=%0b want 0 1 0 1",
                              display_en, loader_start, pix_written, busy);
        end
        wait_on(2, 1100, n, seen);
        tests++;
        if (!seen || n != 1025 || error !== 1'b1 || display_en !== 1'b1) begin
            fails++; $display("FAIL load_timeout: seen=%0d cycles=%0d err=%0b disp=%0b want 1 1025 1 1",
                              seen, n, error, display_en);
        end
        pulse_start();
        tests++;
        if (error !== 1'b0 || loader_start !== 1'b1 || display_en !== 1'b0) begin
            fails++; $display("FAIL restart_clears_error: err=%0b kick=%0b disp=%0b want 0 1 0",
                              error, loader_start, display_en);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame();
        test_clip();
        test_zero_tri();
        test_draw_timeout();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
